// File: rtl/div_pkg.sv
// Types, constants and helpers for the multi-cycle divide/remainder sequencer.
package div_pkg;
`include "mydefine.sv"

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] F_DIV  = `F_DIV;
  localparam logic [2:0] F_DIVU = `F_DIVU;
  localparam logic [2:0] F_REM  = `F_REM;
  localparam logic [2:0] F_REMU = `F_REMU;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Encoding matches funct3[1:0] so decode is a plain cast.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  localparam logic [DIV_XLEN-1:0] DIV0_Q = '1;
  localparam logic [DIV_XLEN-1:0] OVF_Q  = {1'b1, {(DIV_XLEN-1){1'b0}}};

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [DIV_XLEN-1:0] abs_val(input logic [DIV_XLEN-1:0] v);
    return v[DIV_XLEN-1] ? -v : v;
  endfunction
endpackage

// File: rtl/div_if.sv
// Pipeline-side request/response bundle of the divide sequencer.
// start is a request level: it is taken only on an edge where ready=1 and flush=0;
// done is a one-cycle pulse and div_out then stays valid until the next accepted start.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] div_out;

  modport master (
    output start, funct3, rs1_value, rs2_value, flush,
    input  ready, busy, stall, done, div_out
  );

  modport slave (
    input  start, funct3, rs1_value, rs2_value, flush,
    output ready, busy, stall, done, div_out
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {remainder, quotient} pair.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0]   sh_rem;
  logic [XLEN-1:0] sh_quo;
  logic            unused_rem_msb;

  // The incoming remainder is always below the divisor, so its top bit is never set.
  assign unused_rem_msb = rem[XLEN];

  always_comb begin
    sh_rem = {rem[XLEN-1:0], quo[XLEN-1]};
    sh_quo = {quo[XLEN-2:0], 1'b0};
    if (sh_rem >= {1'b0, divisor}) begin
      rem_next = sh_rem - {1'b0, divisor};
      quo_next = sh_quo | XLEN'(1);
    end else begin
      rem_next = sh_rem;
      quo_next = sh_quo;
    end
  end
endmodule

// File: rtl/mydefine.sv
// Shared RV32 decode codes. Only the M-extension divide/remainder funct3 values live here.
`ifndef MYDEFINE_SV
`define MYDEFINE_SV
`define F_DIV  3'b100
`define F_DIVU 3'b101
`define F_REM  3'b110
`define F_REMU 3'b111
`endif

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: magnitude restoring divide, then sign fix-up.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output div_state_e dbg_state
);
  localparam int               CALC_CYCLES = XLEN / BITS_PER_CYCLE;
  localparam int               CNT_W       = $clog2(CALC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CALC_CYCLES - 1);

  div_state_e       state;
  div_op_e          op;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;
  logic [XLEN:0]    rem_r;
  logic [XLEN-1:0]  quo_r, dvs_r, res_r;
  logic             ready_r, busy_r, done_r;

  div_op_e          in_op;
  logic             in_signed, div_zero, ovf, unused_f2;
  logic [XLEN-1:0]  a_mag, b_mag, spec_res;
  logic [XLEN:0]    rem1, rem_n;
  logic [XLEN-1:0]  quo1, quo_n;

  // funct3[2] is always 1 for M-extension divides and carries no information.
  assign unused_f2 = bus.funct3[2];

  always_comb begin
    in_op     = div_op_e'(bus.funct3[1:0]);
    in_signed = (in_op == OP_DIV) || (in_op == OP_REM);
    a_mag     = in_signed ? abs_val(bus.rs1_value) : bus.rs1_value;
    b_mag     = in_signed ? abs_val(bus.rs2_value) : bus.rs2_value;
    div_zero  = (bus.rs2_value == '0);
    ovf       = in_signed && (bus.rs1_value == OVF_Q) && (bus.rs2_value == '1);
    if (div_zero) begin
      spec_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? DIV0_Q : bus.rs1_value;
    end else begin
      spec_res = (in_op == OP_DIV) ? OVF_Q : '0;
    end
  end

  div_step #(.XLEN(XLEN)) u_step0 (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvs_r),
    .rem_next (rem1),
    .quo_next (quo1)
  );

  generate
    if (BITS_PER_CYCLE == 2) begin : g_two
      div_step #(.XLEN(XLEN)) u_step1 (
        .rem      (rem1),
        .quo      (quo1),
        .divisor  (dvs_r),
        .rem_next (rem_n),
        .quo_next (quo_n)
      );
    end else begin : g_one
      assign rem_n = rem1;
      assign quo_n = quo1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op      <= OP_DIV;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      res_r   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op      <= in_op;
            neg_q   <= in_signed && (bus.rs1_value[XLEN-1] ^ bus.rs2_value[XLEN-1]);
            neg_r   <= in_signed && bus.rs1_value[XLEN-1];
            rem_r   <= '0;
            quo_r   <= a_mag;
            dvs_r   <= b_mag;
            cnt     <= '0;
            ready_r <= 1'b0;
            if (div_zero || ovf) begin
              res_r  <= spec_res;
              done_r <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state   <= S_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            rem_r <= rem_n;
            quo_r <= quo_n;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          busy_r <= 1'b0;
          if (bus.flush) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
          end else begin
            case (op)
              OP_DIV:  res_r <= neg_q ? -quo_r : quo_r;
              OP_REM:  res_r <= neg_r ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
              OP_DIVU: res_r <= quo_r;
              default: res_r <= rem_r[XLEN-1:0];
            endcase
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.div_out = res_r;
  assign bus.stall   = (bus.start & ready_r & ~bus.flush) | busy_r;
  assign dbg_state   = state;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: one instance at 1 bit/cycle and one at 2 bits/cycle, same operands,
// results and latency compared against a RISC-V arithmetic model.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, start2, flush;
  logic [2:0]  fn;
  logic [31:0] op_a, op_b;
  div_state_e  st1, st2;

  div_if #(.XLEN(XLEN)) bus1 ();
  div_if #(.XLEN(XLEN)) bus2 ();

  assign bus1.start = start1;
  assign bus1.funct3 = fn;
  assign bus1.rs1_value = op_a;
  assign bus1.rs2_value = op_b;
  assign bus1.flush = flush;
  assign bus2.start = start2;
  assign bus2.funct3 = fn;
  assign bus2.rs1_value = op_a;
  assign bus2.rs2_value = op_b;
  assign bus2.flush = flush;

  div_seq_ctrl #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .dbg_state (st1)
  );

  div_seq_ctrl #(.XLEN(XLEN), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .dbg_state (st2)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    int  sa, sb;
    logic ovf_case;
    sa = $signed(a);
    sb = $signed(b);
    ovf_case = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf_case) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F_REM: begin
        if (b == 0) return a;
        if (ovf_case) return 32'h0;
        return 32'(sa % sb);
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_fn();
    return {1'b1, 2'($urandom_range(0, 3))};
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit chk_busy);
    int lat;
    int exp_lat1, exp_lat2;
    bit got1, got2, pc1, pc2;
    exp_q.push_back(golden(f, a, b));
    exp_lat1 = is_special(f, a, b) ? 1 : XLEN + 2;
    exp_lat2 = is_special(f, a, b) ? 1 : XLEN / 2 + 2;
    fn = f; op_a = a; op_b = b;
    start1 = 1'b1; start2 = 1'b1;
    lat = 0; got1 = 0; got2 = 0; pc1 = 0; pc2 = 0;
    while (!(got1 && got2) && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
      if (got1 && !pc1) begin chk("done_pulse1", 32'(bus1.done), 32'd0); pc1 = 1; end
      if (got2 && !pc2) begin chk("done_pulse2", 32'(bus2.done), 32'd0); pc2 = 1; end
      if (!got1) begin
        if (bus1.done) begin
          got1 = 1; start1 = 1'b0;
          chk("lat1", 32'(lat), 32'(exp_lat1));
          chk("res1", bus1.div_out, exp_q[0]);
        end else if (chk_busy) begin
          chk("ready1", 32'(bus1.ready), 32'd0);
          chk("stall1", 32'(bus1.stall), 32'd1);
        end
      end
      if (!got2) begin
        if (bus2.done) begin
          got2 = 1; start2 = 1'b0;
          chk("lat2", 32'(lat), 32'(exp_lat2));
          chk("res2", bus2.div_out, exp_q[0]);
        end else if (chk_busy) begin
          chk("ready2", 32'(bus2.ready), 32'd0);
          chk("stall2", 32'(bus2.stall), 32'd1);
        end
      end
      if (hold) begin op_a = $urandom; op_b = $urandom; fn = pick_fn(); end
    end
    start1 = 1'b0; start2 = 1'b0;
    if (!got1) chk("timeout1", 32'd0, 32'd1);
    if (!got2) chk("timeout2", 32'd0, 32'd1);
    @(negedge clk);
    if (got1 && !pc1) chk("done_pulse1", 32'(bus1.done), 32'd0);
    if (got2 && !pc2) chk("done_pulse2", 32'(bus2.done), 32'd0);
    last_exp = exp_q.pop_front();
  endtask

  task automatic flush_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit saw;
    fn = f; op_a = a; op_b = b;
    start1 = 1'b1; start2 = 1'b1; saw = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      if (bus1.done || bus2.done) saw = 1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready1", 32'(bus1.ready), 32'd1);
    chk("flush_busy1", 32'(bus1.busy), 32'd0);
    chk("flush_out1", bus1.div_out, last_exp);
    chk("flush_ready2", 32'(bus2.ready), 32'd1);
    chk("flush_busy2", 32'(bus2.busy), 32'd0);
    chk("flush_out2", bus2.div_out, last_exp);
    for (int n = 0; n < 4; n++) begin
      if (bus1.done || bus2.done) saw = 1;
      @(negedge clk);
    end
    chk("flush_nodone", 32'(saw), 32'd0);
  endtask

  task automatic rst_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit saw;
    fn = f; op_a = a; op_b = b;
    start1 = 1'b1; start2 = 1'b1; saw = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_ready1", 32'(bus1.ready), 32'd1);
    chk("arst_busy1", 32'(bus1.busy), 32'd0);
    chk("arst_out1", bus1.div_out, 32'd0);
    chk("arst_ready2", 32'(bus2.ready), 32'd1);
    chk("arst_busy2", 32'(bus2.busy), 32'd0);
    chk("arst_out2", bus2.div_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'd0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus1.done || bus2.done) saw = 1;
    end
    chk("arst_nodone", 32'(saw), 32'd0);
    chk("arst_state1", 32'(st1), 32'(S_IDLE));
  endtask

  task automatic idle_flush();
    fn = F_DIVU; op_a = 32'd50; op_b = 32'd5;
    start1 = 1'b1; start2 = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("iflush_ready1", 32'(bus1.ready), 32'd1);
    chk("iflush_ready2", 32'(bus2.ready), 32'd1);
    chk("iflush_busy1", 32'(bus1.busy), 32'd0);
    start1 = 1'b0; start2 = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("iflush_done1", 32'(bus1.done), 32'd0);
    chk("iflush_done2", 32'(bus2.done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; flush = 1'b0;
    fn = F_DIVU; op_a = '0; op_b = '0; last_exp = '0;
    @(posedge clk);
    #1;
    chk("rst_ready1", 32'(bus1.ready), 32'd1);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    chk("rst_done1", 32'(bus1.done), 32'd0);
    chk("rst_out1", bus1.div_out, 32'd0);
    chk("rst_state2", 32'(st2), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(F_DIVU, 32'd100, 32'd7, 0, 1);
    run_op(F_REMU, 32'd100, 32'd7, 0, 1);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(F_REM, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(F_DIV, 32'd5, 32'd0, 0, 0);
    run_op(F_REMU, 32'd5, 32'd0, 0, 0);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    flush_op(F_DIVU, 32'd1000, 32'd3);
    run_op(F_DIVU, 32'd1000, 32'd3, 0, 0);
    idle_flush();
    rst_op(F_DIV, 32'd999, 32'd4);
    run_op(F_DIV, 32'd12345, 32'd77, 1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = pick_fn();
      a = pick_val();
      b = pick_val();
      run_op(f, a, b, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
